// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and state encodings for counter_updown.
package counter_pkg;
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_e;
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cnt_state_e;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits tick on every (div+1)-th enabled cycle; clr restarts the period.
module counter_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] cnt;
    assign tick = en && cnt == div;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/counter_updown.sv
// counter_updown: up/down counter with wrap/saturate/one-shot boundaries, tc pulse, sticky ovf.
// Define COUNTER_PRESCALE_EN to insert counter_prescaler in front of the step enable.
module counter_updown
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_VAL    = 2**WIDTH-1,
    parameter int RESET_VAL  = 0,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  cnt_mode_e             mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clr_ovf,
    input  logic [PRESCALE_W-1:0] prescale_div,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  halted
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
    cnt_state_e       state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt, ovf_nxt, tick, step, at_bound, bnd, hold;
`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .div (prescale_div),
        .tick(tick)
    );
`else
    logic unused_div;
    assign unused_div = ^prescale_div;
    assign tick = 1'b1;
`endif
    always_comb begin
        step      = en && tick && state == ST_RUN;
        at_bound  = up_dn ? count == MAX : count == '0;
        bnd       = !load && step && at_bound;
        hold      = mode == CNT_SAT || mode == CNT_ONESHOT;
        count_nxt = load ? (32'(load_val) > MAX_VAL ? MAX : load_val) :
                    !step ? count :
                    !at_bound ? (up_dn ? count + WIDTH'(1) : count - WIDTH'(1)) :
                    hold ? count : (up_dn ? '0 : MAX);
        state_nxt = load ? ST_RUN : (bnd && mode == CNT_ONESHOT) ? ST_HALT : state;
        tc_nxt    = bnd;
        ovf_nxt   = bnd || (ovf && !clr_ovf);
    end
    always_ff @(posedge clk)
        if (rst) begin
            count <= RST;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            state <= ST_RUN;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
            state <= state_nxt;
        end
    assign halted = state == ST_HALT;
endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: directed and random checks of counter_updown against a behavioural model.
module tb_counter_updown;
    import counter_pkg::*;
    localparam int W  = 4;
    localparam int MX = 9;
    logic         clk = 1'b0;
    logic         rst, en, up_dn, load, clr_ovf;
    cnt_mode_e    mode;
    logic [W-1:0] load_val;
    logic [3:0]   prescale_div;
    logic [W-1:0] count;
    logic         tc, ovf, halted;
    int n_vec = 0, n_err = 0;
    int m_cnt = 0, m_pre = 0;
    bit m_tc = 0, m_ovf = 0, m_halt = 0;

    counter_updown #(.WIDTH(W), .MAX_VAL(MX), .RESET_VAL(0), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .prescale_div(prescale_div),
        .count(count), .tc(tc), .ovf(ovf), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model();
        bit tick, stp, bnd;
        if (rst) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_halt = 0; m_pre = 0;
        end else if (load) begin
            m_cnt  = (int'(load_val) > MX) ? MX : int'(load_val);
            m_halt = 0; m_tc = 0; m_pre = 0;
            m_ovf  = m_ovf && !clr_ovf;
        end else begin
`ifdef COUNTER_PRESCALE_EN
            tick = en && m_pre == int'(prescale_div);
            if (en) m_pre = tick ? 0 : m_pre + 1;
`else
            tick = 1;
`endif
            stp = en && tick && !m_halt;
            bnd = stp && (up_dn ? m_cnt == MX : m_cnt == 0);
            if (stp && !bnd) m_cnt = m_cnt + (up_dn ? 1 : -1);
            else if (bnd && mode != CNT_SAT && mode != CNT_ONESHOT)
                m_cnt = (m_cnt + (up_dn ? 1 : MX)) % (MX + 1);
            if (bnd && mode == CNT_ONESHOT) m_halt = 1;
            m_tc  = bnd;
            m_ovf = bnd || (m_ovf && !clr_ovf);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit u, input cnt_mode_e m,
                       input bit l, input int lv, input bit c);
        rst = r; en = e; up_dn = u; mode = m; load = l; load_val = W'(lv); clr_ovf = c;
        @(posedge clk);
        model();
        #1;
        chk("count", count, m_cnt);
        chk("tc", tc, m_tc);
        chk("ovf", ovf, m_ovf);
        chk("halted", halted, m_halt);
    endtask

    initial begin
        prescale_div = 4'd0;
        // wrap up through MAX_VAL
        cyc(1, 0, 1, CNT_WRAP, 0, 0, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        repeat (10) cyc(0, 1, 1, CNT_WRAP, 0, 0, 0);
        chk("wrap_zero", count, 0);
        chk("wrap_tc", tc, 1);
        cyc(0, 1, 1, CNT_WRAP, 0, 0, 0);
        chk("wrap_one", count, 1);
        chk("wrap_tc_off", tc, 0);
        // saturate down at 0
        cyc(0, 0, 0, CNT_SAT, 1, 3, 0);
        repeat (5) cyc(0, 1, 0, CNT_SAT, 0, 0, 0);
        chk("sat_count", count, 0);
        chk("sat_tc", tc, 1);
        chk("sat_ovf", ovf, 1);
        // one-shot halts at MAX_VAL
        cyc(0, 0, 1, CNT_ONESHOT, 1, 8, 0);
        repeat (3) cyc(0, 1, 1, CNT_ONESHOT, 0, 0, 0);
        chk("os_count", count, 9);
        chk("os_halted", halted, 1);
        cyc(0, 1, 0, CNT_WRAP, 0, 0, 0);
        chk("os_mode_chg", halted, 1);
        cyc(0, 0, 1, CNT_ONESHOT, 1, 2, 0);
        chk("os_reload_h", halted, 0);
        chk("os_reload_c", count, 2);
        // load clamp and load priority over step
        cyc(0, 0, 1, CNT_WRAP, 1, 15, 0);
        chk("clamp", count, 9);
        cyc(0, 1, 1, CNT_WRAP, 1, 4, 0);
        chk("load_prio", count, 4);
        // clr_ovf against a same-cycle boundary event
        cyc(0, 0, 1, CNT_SAT, 1, 9, 0);
        cyc(0, 1, 1, CNT_SAT, 0, 0, 1);
        chk("clr_vs_set", ovf, 1);
        cyc(0, 0, 1, CNT_SAT, 0, 0, 1);
        chk("clr_alone", ovf, 0);
`ifdef COUNTER_PRESCALE_EN
        prescale_div = 4'd2;
        cyc(1, 0, 1, CNT_WRAP, 0, 0, 0);
        repeat (7) cyc(0, 1, 1, CNT_WRAP, 0, 0, 0);
        chk("pre_count", count, 2);
        cyc(1, 1, 1, CNT_WRAP, 0, 0, 0);
        repeat (2) cyc(0, 1, 1, CNT_WRAP, 0, 0, 0);
        chk("pre_restart", count, 0);
        cyc(0, 1, 1, CNT_WRAP, 0, 0, 0);
        chk("pre_period", count, 1);
        prescale_div = 4'd1;
`endif
        cyc(1, 0, 1, CNT_WRAP, 0, 0, 0);
        repeat (600)
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                cnt_mode_e'(2'($urandom_range(0, 3))), $urandom_range(0, 11) == 0,
                $urandom_range(0, 15), $urandom_range(0, 7) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
